instr_fetch: RTL

Fetch stage of the KGP-RISC multicycle core, directly upstream of the control unit. Holds the program counter and issues word reads to instruction memory over a request/valid handshake. Latches the returned word into the instruction register and splits out the opcode, opcode_ext and register/immediate fields the control unit and register file consume. Also handles branch redirects, including discarding a read already in flight.

---
 rtl/kgp_isa_pkg.sv | 30 +++
 rtl/instr_field_split.sv | 22 ++
 rtl/instr_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/kgp_isa_pkg.sv
// Shared KGP-RISC ISA definitions: fetch state encoding, instruction field positions, NOP word.
package kgp_isa_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;
  localparam int EXT_MSB = 10;
  localparam int EXT_LSB = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Branch targets are byte addresses; fetch only ever uses word-aligned ones.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into the fields the control unit and
// register file consume.
module instr_field_split
  import kgp_isa_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic [10:0] opcode_ext
);

  assign opcode     = ir[OPC_MSB:OPC_LSB];
  assign rs         = ir[RS_MSB:RS_LSB];
  assign rt         = ir[RT_MSB:RT_LSB];
  assign imm16      = ir[IMM_MSB:IMM_LSB];
  assign target26   = ir[TGT_MSB:TGT_LSB];
  assign opcode_ext = ir[EXT_MSB:EXT_LSB];

endmodule

// File: rtl/instr_fetch.sv
// KGP-RISC fetch stage: program counter, instruction-memory handshake, instruction
// register and branch redirect with cancellation of a stale in-flight read.
//
//   state | meaning
//   ISSUE | drive imem_req for pc; any imem_valid seen here is ignored
//   WAIT  | read outstanding; drop=1 means its data belongs to a redirected-away pc
//   HOLD  | ir holds a live instruction until instr_ack or redirect
module instr_fetch
  import kgp_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               instr_ack,
  output logic               instr_valid,
  output logic [31:0]        pc_out,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [15:0]        imm16,
  output logic [25:0]        target26,
  output logic [10:0]        opcode_ext
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic         drop;
  logic [31:0]  redirect_target;

  assign redirect_target = align_word(redirect_pc);

  assign imem_req  = (state == ISSUE) & ~rst;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign pc_out    = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      ir          <= NOP_WORD;
      instr_valid <= 1'b0;
      drop        <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          state <= WAIT;
          // The read just issued is for the old pc, so its data must be discarded.
          if (redirect) begin
            pc   <= redirect_target;
            drop <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= redirect_target;
            if (imem_valid) begin
              drop  <= 1'b0;
              state <= ISSUE;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ISSUE;
            end else begin
              ir          <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc          <= redirect_target;
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end else if (instr_ack) begin
            pc          <= pc + 32'd4;
            instr_valid <= 1'b0;
            state       <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  instr_field_split u_split (
    .ir         (ir),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .imm16      (imm16),
    .target26   (target26),
    .opcode_ext (opcode_ext)
  );

endmodule
